// File: rtl/grey_mod_n.sv
// grey_mod_n: cyclic Gray counter of even modulus with divided clock, wrap strobe and post-reset stretch
module grey_mod_n #(
  parameter int MOD = 10,
  parameter int HIGH = 5,
  parameter int STRETCH = 8,
  localparam int W = $clog2(MOD)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_dir,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_idx,
  output logic         o_clk_div,
  output logic         o_wrap,
  output logic         o_ready
);
  localparam int SW = $clog2(STRETCH + 1);
  localparam logic [W-1:0] BASE = W'(((1 << W) - MOD) / 2);
  localparam logic [W-1:0] LAST = W'(MOD - 1);
  localparam logic [W-1:0] HIGH_W = W'(HIGH);
  typedef enum logic {ST_HOLD, ST_RUN} state_t;
  state_t state, state_nx;
  logic [SW-1:0] stretch, stretch_nx;
  logic [W-1:0] idx_nx, bin_nx;
  logic last_hit, wrap_nx;
  // The code set is centred in the 2^W Gray space so the first and last codes differ only in the MSB.
  assign last_hit = i_dir ? o_idx == '0 : o_idx == LAST;
  assign idx_nx = state != ST_RUN ? o_idx :
                  i_clr ? '0 :
                  !i_en ? o_idx :
                  last_hit ? (i_dir ? LAST : '0) :
                  i_dir ? o_idx - 1'b1 : o_idx + 1'b1;
  assign wrap_nx = state == ST_RUN && !i_clr && i_en && last_hit;
  assign bin_nx = idx_nx + BASE;
  assign o_ready = state == ST_RUN;
  always_comb begin
    state_nx = state;
    stretch_nx = stretch;
    if (state == ST_HOLD) begin
      stretch_nx = stretch - 1'b1;
      state_nx = stretch == SW'(1) ? ST_RUN : ST_HOLD;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_HOLD;
      stretch <= SW'(STRETCH);
      o_idx <= '0;
      o_cnt <= BASE ^ (BASE >> 1);
      o_clk_div <= 1'b1;
      o_wrap <= 1'b0;
    end else begin
      state <= state_nx;
      stretch <= stretch_nx;
      o_idx <= idx_nx;
      o_cnt <= bin_nx ^ (bin_nx >> 1);
      o_clk_div <= idx_nx < HIGH_W;
      o_wrap <= wrap_nx;
    end
  end
endmodule

// File: tb/tb_grey_mod_n.sv
// tb_grey_mod_n: five parameterisations of grey_mod_n driven together against an arithmetic reference model
module tb_grey_mod_n;
  localparam int N = 5;
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, dir = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int p_mod[N] = '{10, 2, 16, 12, 12};
  int p_high[N] = '{5, 1, 15, 1, 11};
  int p_str[N] = '{8, 1, 3, 2, 1};
  logic [3:0] c0, x0, c2, x2, c3, x3, c4, x4;
  logic c1, x1;
  logic [N-1:0] dv, wr, rd;
  int oc[N], ox[N];
  int m_idx[N], m_sc[N], prev[N], wraps[N], highs[N];
  bit m_rdy[N], m_wrap[N], m_step[N];
  grey_mod_n #(.MOD(10), .HIGH(5), .STRETCH(8)) u0 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_clr(clr),
    .o_cnt(c0), .o_idx(x0), .o_clk_div(dv[0]), .o_wrap(wr[0]), .o_ready(rd[0]));
  grey_mod_n #(.MOD(2), .HIGH(1), .STRETCH(1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_clr(clr),
    .o_cnt(c1), .o_idx(x1), .o_clk_div(dv[1]), .o_wrap(wr[1]), .o_ready(rd[1]));
  grey_mod_n #(.MOD(16), .HIGH(15), .STRETCH(3)) u2 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_clr(clr),
    .o_cnt(c2), .o_idx(x2), .o_clk_div(dv[2]), .o_wrap(wr[2]), .o_ready(rd[2]));
  grey_mod_n #(.MOD(12), .HIGH(1), .STRETCH(2)) u3 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_clr(clr),
    .o_cnt(c3), .o_idx(x3), .o_clk_div(dv[3]), .o_wrap(wr[3]), .o_ready(rd[3]));
  grey_mod_n #(.MOD(12), .HIGH(11), .STRETCH(1)) u4 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_clr(clr),
    .o_cnt(c4), .o_idx(x4), .o_clk_div(dv[4]), .o_wrap(wr[4]), .o_ready(rd[4]));
  always_comb begin
    oc[0] = int'(c0); oc[1] = int'(c1); oc[2] = int'(c2); oc[3] = int'(c3); oc[4] = int'(c4);
    ox[0] = int'(x0); ox[1] = int'(x1); ox[2] = int'(x2); ox[3] = int'(x3); ox[4] = int'(x4);
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int gray_of(input int k, input int i);
    int w, b, x;
    w = $clog2(p_mod[k]);
    b = ((1 << w) - p_mod[k]) / 2;
    x = i + b;
    return x ^ (x >> 1);
  endfunction
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_idx[k] = 0; m_sc[k] = p_str[k]; m_rdy[k] = 0; m_wrap[k] = 0; m_step[k] = 0;
    end
  endtask
  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      m_step[k] = 0;
      m_wrap[k] = 0;
      if (!m_rdy[k]) begin
        m_sc[k]--;
        if (m_sc[k] == 0) m_rdy[k] = 1;
      end else if (clr) m_idx[k] = 0;
      else if (en) begin
        m_step[k] = 1;
        m_wrap[k] = dir ? m_idx[k] == 0 : m_idx[k] == p_mod[k] - 1;
        m_idx[k] = dir ? (m_idx[k] + p_mod[k] - 1) % p_mod[k] : (m_idx[k] + 1) % p_mod[k];
      end
    end
  endtask
  task automatic compare_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("u%0d_cnt", k), oc[k], gray_of(k, m_idx[k]));
      chk($sformatf("u%0d_idx", k), ox[k], m_idx[k]);
      chk($sformatf("u%0d_clk_div", k), int'(dv[k]), int'(m_idx[k] < p_high[k]));
      chk($sformatf("u%0d_wrap", k), int'(wr[k]), int'(m_wrap[k]));
      chk($sformatf("u%0d_ready", k), int'(rd[k]), int'(m_rdy[k]));
      if (m_step[k]) chk($sformatf("u%0d_hamming", k), $countones(oc[k] ^ prev[k]), 1);
      prev[k] = oc[k];
      wraps[k] += int'(wr[k]);
      highs[k] += int'(dv[k]);
    end
  endtask
  task automatic cycle(input logic e, input logic d, input logic c);
    en = e; dir = d; clr = c;
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    @(negedge clk);
    compare_all();
  endtask
  task automatic clear_stats();
    for (int k = 0; k < N; k++) begin
      wraps[k] = 0; highs[k] = 0;
    end
  endtask
  task automatic check_window(input int len);
    for (int k = 1; k < N; k++) begin
      chk($sformatf("u%0d_wrap_count", k), wraps[k], len / p_mod[k]);
      chk($sformatf("u%0d_duty", k), highs[k], len / p_mod[k] * p_high[k]);
    end
  endtask
  initial begin
    logic e, d, c;
    #1 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    chk("rst_cnt", int'(c0), 4'b0010);
    chk("rst_clk_div", int'(dv[0]), 1);
    chk("rst_ready", int'(rd[0]), 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    rst_n = 1'b1;
    repeat (7) cycle(1, 0, 0);
    chk("ready_edge7", int'(rd[0]), 0);
    cycle(1, 0, 0);
    chk("ready_edge8", int'(rd[0]), 1);
    chk("idx_edge8", int'(x0), 0);
    cycle(1, 0, 0);
    chk("idx_edge9", int'(x0), 1);
    chk("cnt_edge9", int'(c0), 4'b0110);
    clear_stats();
    repeat (30) cycle(1, 0, 0);
    chk("up30_wraps", wraps[0], 3);
    chk("up30_duty", highs[0], 15);
    cycle(0, 0, 1);
    cycle(1, 1, 0);
    chk("down_idx", int'(x0), 9);
    chk("down_cnt", int'(c0), 4'b1010);
    chk("down_wrap", int'(wr[0]), 1);
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    chk("down_to7", int'(x0), 7);
    cycle(1, 0, 0);
    chk("reverse_idx", int'(x0), 8);
    for (int i = 0; i < 300; i++) begin
      e = $urandom_range(0, 99) >= 40;
      d = 1'($urandom_range(0, 1));
      c = $urandom_range(0, 99) < 3;
      cycle(e, d, c);
      if (!e && !c) chk("idle_wrap", int'(wr[0]), 0);
    end
    cycle(0, 0, 1);
    repeat (7) cycle(1, 0, 0);
    chk("pre_clr_idx", int'(x0), 7);
    cycle(1, 0, 1);
    chk("clr_idx", int'(x0), 0);
    chk("clr_cnt", int'(c0), 4'b0010);
    chk("clr_clk_div", int'(dv[0]), 1);
    chk("clr_wrap", int'(wr[0]), 0);
    cycle(0, 0, 1);
    repeat (6) cycle(1, 0, 0);
    chk("pre_rst_idx", int'(x0), 6);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    chk("async_cnt", int'(c0), 4'b0010);
    chk("async_ready", int'(rd[0]), 0);
    @(negedge clk);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    rst_n = 1'b1;
    repeat (7) cycle(1, 0, 0);
    chk("rerelease_edge7", int'(rd[0]), 0);
    cycle(1, 0, 0);
    chk("rerelease_edge8", int'(rd[0]), 1);
    clear_stats();
    repeat (48) cycle(1, 0, 0);
    check_window(48);
    clear_stats();
    repeat (48) cycle(1, 1, 0);
    check_window(48);
    for (int i = 0; i < 200; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
